mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single 128-bit main-memory port between two cache clients (0 = icache, 1 = dcache).
//  Grants one client at a time with round-robin priority, forwards its request/write-data handshakes,
//  and routes the BEATS-beat line-fill response back to the owner. Sits between both caches and memory.
// PARAMETERS
//  ADDR_BITS  28   line-beat address width (word address [29:2])
//  DATA_BITS  128  memory beat width; mask width is DATA_BITS/8
//  BEATS      4    response beats per read (512-bit line)
// PORTS
//  clk               in   1              clock, all state on rising edge
//  reset             in   1              asynchronous, active-high
//  c_req_valid       in   2              per-client request valid
//  c_req_ready       out  2              per-client request accepted
//  c_req_addr        in   2*ADDR_BITS    client n in [n*ADDR_BITS +: ADDR_BITS]
//  c_req_rw          in   2              1 = write, 0 = read
//  c_req_data_valid  in   2              per-client write-data valid
//  c_req_data_ready  out  2              per-client write-data accepted
//  c_req_data_bits   in   2*DATA_BITS    client n in [n*DATA_BITS +: DATA_BITS]
//  c_req_data_mask   in   2*DATA_BITS/8  byte mask per client
//  c_resp_valid      out  2              response beat for client n
//  c_resp_data       out  DATA_BITS      response data, shared by both clients
//  mem_req_valid     out  1              memory request valid
//  mem_req_ready     in   1              memory request accepted
//  mem_req_addr      out  ADDR_BITS      memory address
//  mem_req_rw        out  1              1 = write
//  mem_req_data_valid out 1              write data valid
//  mem_req_data_ready in  1              write data accepted
//  mem_req_data_bits out  DATA_BITS      write data
//  mem_req_data_mask out  DATA_BITS/8    byte write mask
//  mem_resp_valid    in   1              read response beat
//  mem_resp_data     in   DATA_BITS      read response data
//  err_spurious      out  1              sticky: mem_resp_valid seen outside READ_RESP
// BEHAVIOUR
//  - Reset (async): state=IDLE, rr_ptr=0 (client 0 preferred), beat_cnt=0, req_done/data_done=0,
//    err_spurious=0; all valid/ready outputs 0 immediately on assertion.
//  - States: IDLE, WRITE, READ_REQ, READ_RESP. owner is a registered 1-bit index.
//  - IDLE: all mem_req_*valid and c_*ready outputs 0 (no comb path from c_req_valid to memory).
//    If any c_req_valid: winner = sole requester, or rr_ptr if both. owner<=winner;
//    next = WRITE if c_req_rw[winner] else READ_REQ. One-cycle grant latency.
//  - WRITE: mem_req_valid=c_req_valid[owner] & !req_done; mem_req_data_valid=c_req_data_valid[owner] & !data_done;
//    addr/rw/data/mask muxed from owner; c_req_ready[owner]=mem_req_ready & !req_done;
//    c_req_data_ready[owner]=mem_req_data_ready & !data_done. req_done/data_done set on each handshake
//    (same or different cycles). When both complete -> IDLE, rr_ptr<=~owner, flags cleared.
//  - READ_REQ: mem_req_valid=c_req_valid[owner], rw=0, data_valid=0; on handshake -> READ_RESP, beat_cnt<=0.
//  - WRITE/READ_REQ with no handshake yet and c_req_valid[owner]=0 -> IDLE, rr_ptr unchanged.
//  - READ_RESP: mem_req_valid=0 and c_req_ready=0 even if owner still holds valid (caches keep valid
//    until first beat). c_resp_valid[owner]=mem_resp_valid (combinational, 0 latency);
//    beat_cnt (clog2(BEATS) bits, wraps) increments per beat; on beat BEATS-1 -> IDLE, rr_ptr<=~owner.
//  - c_resp_data = mem_resp_data always. Non-owner ready/resp_valid outputs always 0.
//  - mem_resp_valid in IDLE/WRITE/READ_REQ: not routed, err_spurious<=1 until reset.
//  - Back-to-back: one IDLE cycle between transactions; simultaneous new request and completion
//    is arbitrated in the following IDLE cycle with the updated rr_ptr.
// TESTING
//  T1 client0 read addr 0x0000123, mem ready -> one mem req, beats D0..D3 on c_resp_valid[0]; [1]=0; IDLE.
//  T2 both read from reset -> grants 0,1,0 for three rounds; each pays one IDLE cycle.
//  T3 client1 write mask 0xFFFF, req_ready cycle n, data_ready n+3 -> done n+3, each handshake once.
//  T4 owner keeps c_req_valid high in READ_RESP with 5-cycle gaps -> exactly one mem_req handshake.
//  T5 mem_resp_valid pulse in IDLE -> err_spurious=1 sticky, both c_resp_valid 0.
//  T6 reset after beat 2 of READ_RESP -> outputs 0 at once; after release client0 read completes normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//  Groups the two-client cache side and the single memory side of the
//  memory arbiter into one bundle.
//  Client side (index n = 0 icache, 1 dcache, fields packed per client):
//    c_req_valid/ready, c_req_addr, c_req_rw         request handshake
//    c_req_data_valid/ready, c_req_data_bits/mask    write-data handshake
//    c_resp_valid (per client), c_resp_data (shared) read response beats
//  Memory side:
//    mem_req_valid/ready, mem_req_addr, mem_req_rw   request handshake
//    mem_req_data_valid/ready, _bits, _mask          write-data handshake
//    mem_resp_valid, mem_resp_data                   read response beats
//  Modports: master = arbiter view, slave = environment (caches + memory).
interface mem_arbiter_if #(
  parameter int ADDR_BITS = 28,
  parameter int DATA_BITS = 128
);
  logic [1:0]               c_req_valid;
  logic [1:0]               c_req_ready;
  logic [2*ADDR_BITS-1:0]   c_req_addr;
  logic [1:0]               c_req_rw;
  logic [1:0]               c_req_data_valid;
  logic [1:0]               c_req_data_ready;
  logic [2*DATA_BITS-1:0]   c_req_data_bits;
  logic [2*DATA_BITS/8-1:0] c_req_data_mask;
  logic [1:0]               c_resp_valid;
  logic [DATA_BITS-1:0]     c_resp_data;
  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic [ADDR_BITS-1:0]     mem_req_addr;
  logic                     mem_req_rw;
  logic                     mem_req_data_valid;
  logic                     mem_req_data_ready;
  logic [DATA_BITS-1:0]     mem_req_data_bits;
  logic [DATA_BITS/8-1:0]   mem_req_data_mask;
  logic                     mem_resp_valid;
  logic [DATA_BITS-1:0]     mem_resp_data;

  modport master (
    input  c_req_valid, c_req_addr, c_req_rw, c_req_data_valid, c_req_data_bits, c_req_data_mask,
    output c_req_ready, c_req_data_ready, c_resp_valid, c_resp_data,
    output mem_req_valid, mem_req_addr, mem_req_rw, mem_req_data_valid, mem_req_data_bits,
    output mem_req_data_mask,
    input  mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
  );

  modport slave (
    output c_req_valid, c_req_addr, c_req_rw, c_req_data_valid, c_req_data_bits, c_req_data_mask,
    input  c_req_ready, c_req_data_ready, c_resp_valid, c_resp_data,
    input  mem_req_valid, mem_req_addr, mem_req_rw, mem_req_data_valid, mem_req_data_bits,
    input  mem_req_data_mask,
    output mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//  Shares one 128-bit main-memory port between the icache (client 0) and the
//  dcache (client 1). One client owns the port per transaction; ownership is
//  decided in IDLE with round-robin priority when both request. Writes forward
//  the request and write-data handshakes independently; reads forward the
//  request and then route BEATS response beats to the owner.
//  Ports:
//    clk           clock, all state on rising edge
//    reset         asynchronous, active-high
//    bus           mem_arbiter_if.master (client and memory handshakes)
//    err_spurious  sticky flag: memory response beat seen outside READ_RESP
module mem_arbiter #(
  parameter int ADDR_BITS = 28,
  parameter int DATA_BITS = 128,
  parameter int BEATS     = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus,
  output logic          err_spurious
);
  localparam int MASK_BITS = DATA_BITS / 8;
  localparam int CNT_BITS  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITE     = 2'd1,
    ST_READ_REQ  = 2'd2,
    ST_READ_RESP = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                rr_ptr_q, rr_ptr_d;
  logic                req_done_q, req_done_d;
  logic                data_done_q, data_done_d;
  logic                err_q, err_d;
  logic [CNT_BITS-1:0] beat_cnt_q, beat_cnt_d;

  logic                 own_valid_s, own_rw_s, own_data_valid_s;
  logic [ADDR_BITS-1:0] own_addr_s;
  logic [DATA_BITS-1:0] own_data_s;
  logic [MASK_BITS-1:0] own_mask_s;
  logic                 winner_s, req_hs_s, data_hs_s;
  logic [1:0]           c_req_ready_s, c_req_data_ready_s, c_resp_valid_s;
  logic                 mem_req_valid_s, mem_req_rw_s, mem_req_data_valid_s;

  // Select the owning client's request fields.
  always_comb begin
    if (owner_q) begin
      own_valid_s      = bus.c_req_valid[1];
      own_rw_s         = bus.c_req_rw[1];
      own_data_valid_s = bus.c_req_data_valid[1];
      own_addr_s       = bus.c_req_addr[2*ADDR_BITS-1:ADDR_BITS];
      own_data_s       = bus.c_req_data_bits[2*DATA_BITS-1:DATA_BITS];
      own_mask_s       = bus.c_req_data_mask[2*MASK_BITS-1:MASK_BITS];
    end else begin
      own_valid_s      = bus.c_req_valid[0];
      own_rw_s         = bus.c_req_rw[0];
      own_data_valid_s = bus.c_req_data_valid[0];
      own_addr_s       = bus.c_req_addr[ADDR_BITS-1:0];
      own_data_s       = bus.c_req_data_bits[DATA_BITS-1:0];
      own_mask_s       = bus.c_req_data_mask[MASK_BITS-1:0];
    end
  end

  // Next-state and handshake-forwarding logic.
  always_comb begin
    state_d              = state_q;
    owner_d              = owner_q;
    rr_ptr_d             = rr_ptr_q;
    req_done_d           = req_done_q;
    data_done_d          = data_done_q;
    beat_cnt_d           = beat_cnt_q;
    err_d                = err_q | (bus.mem_resp_valid & (state_q != ST_READ_RESP));
    c_req_ready_s        = 2'b00;
    c_req_data_ready_s   = 2'b00;
    c_resp_valid_s       = 2'b00;
    mem_req_valid_s      = 1'b0;
    mem_req_rw_s         = 1'b0;
    mem_req_data_valid_s = 1'b0;
    winner_s             = 1'b0;
    req_hs_s             = 1'b0;
    data_hs_s            = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Outputs stay quiet here: the grant registers first, so there is
        // no combinational path from a client valid to memory.
        if (bus.c_req_valid == 2'b11) begin
          winner_s = rr_ptr_q;
        end else begin
          winner_s = bus.c_req_valid[1];
        end
        if (bus.c_req_valid != 2'b00) begin
          owner_d = winner_s;
          state_d = bus.c_req_rw[winner_s] ? ST_WRITE : ST_READ_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        mem_req_valid_s             = own_valid_s & ~req_done_q;
        mem_req_rw_s                = own_rw_s;
        mem_req_data_valid_s        = own_data_valid_s & ~data_done_q;
        c_req_ready_s[owner_q]      = bus.mem_req_ready & ~req_done_q;
        c_req_data_ready_s[owner_q] = bus.mem_req_data_ready & ~data_done_q;
        req_hs_s                    = mem_req_valid_s & bus.mem_req_ready;
        data_hs_s                   = mem_req_data_valid_s & bus.mem_req_data_ready;
        if ((req_done_q | req_hs_s) & (data_done_q | data_hs_s)) begin
          state_d     = ST_IDLE;
          rr_ptr_d    = ~owner_q;
          req_done_d  = 1'b0;
          data_done_d = 1'b0;
        end else if (~req_done_q & ~data_done_q & ~req_hs_s & ~data_hs_s & ~own_valid_s) begin
          // Client withdrew before anything was accepted: give up the port
          // without moving the round-robin pointer.
          state_d     = ST_IDLE;
          req_done_d  = 1'b0;
          data_done_d = 1'b0;
        end else begin
          req_done_d  = req_done_q | req_hs_s;
          data_done_d = data_done_q | data_hs_s;
        end
      end
      ST_READ_REQ: begin
        mem_req_valid_s        = own_valid_s;
        c_req_ready_s[owner_q] = bus.mem_req_ready;
        req_hs_s               = own_valid_s & bus.mem_req_ready;
        if (req_hs_s) begin
          state_d    = ST_READ_RESP;
          beat_cnt_d = {CNT_BITS{1'b0}};
        end else if (~own_valid_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_READ_REQ;
        end
      end
      ST_READ_RESP: begin
        // The cache may still hold its request valid until the first beat;
        // it is deliberately not forwarded again.
        c_resp_valid_s[owner_q] = bus.mem_resp_valid;
        if (bus.mem_resp_valid) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            state_d  = ST_IDLE;
            rr_ptr_d = ~owner_q;
          end else begin
            state_d = ST_READ_RESP;
          end
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      rr_ptr_q    <= 1'b0;
      req_done_q  <= 1'b0;
      data_done_q <= 1'b0;
      err_q       <= 1'b0;
      beat_cnt_q  <= {CNT_BITS{1'b0}};
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      req_done_q  <= req_done_d;
      data_done_q <= data_done_d;
      err_q       <= err_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign bus.c_req_ready        = c_req_ready_s;
  assign bus.c_req_data_ready   = c_req_data_ready_s;
  assign bus.c_resp_valid       = c_resp_valid_s;
  assign bus.c_resp_data        = bus.mem_resp_data;
  assign bus.mem_req_valid      = mem_req_valid_s;
  assign bus.mem_req_addr       = own_addr_s;
  assign bus.mem_req_rw         = mem_req_rw_s;
  assign bus.mem_req_data_valid = mem_req_data_valid_s;
  assign bus.mem_req_data_bits  = own_data_s;
  assign bus.mem_req_data_mask  = own_mask_s;
  assign err_spurious           = err_q;
endmodule
